// File: rtl/input_fetch.sv
// Streams packed image words as sign-extended pixels, zero-padded to FFT_N x FFT_N, for the FFT stage.
// Optional INPUT_FETCH_PREFETCH_EN overlaps the next word read with emission for 1 sample/cycle.
module input_fetch #(
  parameter int          IMG_W     = 32,
  parameter int          IMG_H     = 32,
  parameter int          FFT_N     = 64,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [15:0]      mem_addr,
  input  logic [31:0]      mem_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last_row,
  output logic             out_last_frame
);

  localparam int              CW     = $clog2(FFT_N + 1);
  localparam logic [CW-1:0]   W_L    = CW'(IMG_W);
  localparam logic [CW-1:0]   H_L    = CW'(IMG_H);
  localparam logic [CW-1:0]   N_L    = CW'(FFT_N);
  localparam logic [CW-1:0]   NM1_L  = CW'(FFT_N - 1);
  localparam logic [15:0]     W16    = 16'(IMG_W);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_LOAD, S_EMIT, S_PAD, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] row, col, row_n, col_n;
  logic [1:0]    lane, lane_n;
  logic [31:0]   buf_q;
  logic [15:0]   row_base;
  logic          fire, row_end;

  function automatic logic [OUT_W-1:0] sext(input logic [7:0] b);
    return OUT_W'($signed(b));
  endfunction

  function automatic logic [1:0] last_flags(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return {(c == NM1_L) && (r == NM1_L), c == NM1_L};
  endfunction

  always_comb begin
    fire    = out_valid && out_ready;
    col_n   = col + CW'(1);
    row_n   = row + CW'(1);
    lane_n  = lane + 2'd1;
    row_end = fire && (((state == S_PAD) && (col == NM1_L)) ||
                       ((state == S_EMIT) && (lane == 2'd3) && (col_n == N_L)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      row            <= '0;
      col            <= '0;
      lane           <= '0;
      buf_q          <= '0;
      row_base       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_addr       <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last_row   <= 1'b0;
      out_last_frame <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          state    <= S_REQ;
          row      <= '0;
          col      <= '0;
          busy     <= 1'b1;
          row_base <= BASE_ADDR;
          mem_addr <= BASE_ADDR;
        end
        S_REQ: state <= S_LOAD;
        S_LOAD: begin
          buf_q     <= mem_q;
          lane      <= '0;
          state     <= S_EMIT;
          out_valid <= 1'b1;
          out_data  <= sext(mem_q[7:0]);
          {out_last_frame, out_last_row} <= last_flags(row, col);
        end
        S_EMIT: if (fire) begin
          col  <= col_n;
          lane <= lane_n;
          if (lane == 2'd3) begin
            if (col_n == W_L) begin
              state    <= S_PAD;
              out_data <= '0;
              {out_last_frame, out_last_row} <= last_flags(row, col_n);
            end else begin
`ifdef INPUT_FETCH_PREFETCH_EN
              // Next word was addressed two lanes ago, so mem_q already holds it.
              buf_q    <= mem_q;
              out_data <= sext(mem_q[7:0]);
              {out_last_frame, out_last_row} <= last_flags(row, col_n);
`else
              state     <= S_REQ;
              out_valid <= 1'b0;
              mem_addr  <= row_base + 16'(col_n);
`endif
            end
          end else begin
            out_data <= sext(buf_q[{lane_n, 3'b000} +: 8]);
            {out_last_frame, out_last_row} <= last_flags(row, col_n);
`ifdef INPUT_FETCH_PREFETCH_EN
            if ((lane == 2'd1) && ((col_n + CW'(2)) < W_L))
              mem_addr <= row_base + 16'(col_n + CW'(2));
`endif
          end
        end
        S_PAD: if (fire && (col != NM1_L)) begin
          col <= col_n;
          {out_last_frame, out_last_row} <= last_flags(row, col_n);
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Row completion is shared by PAD and a full-width final image word; it overrides the case above.
      if (row_end) begin
        col      <= '0;
        row      <= row_n;
        row_base <= row_base + W16;
        if (row_n < H_L) begin
          state     <= S_REQ;
          out_valid <= 1'b0;
          mem_addr  <= row_base + W16;
        end else if (row_n < N_L) begin
          state     <= S_PAD;
          out_valid <= 1'b1;
          out_data  <= '0;
          {out_last_frame, out_last_row} <= last_flags(row_n, '0);
        end else begin
          state          <= S_DONE;
          out_valid      <= 1'b0;
          done           <= 1'b1;
          busy           <= 1'b0;
          out_last_row   <= 1'b0;
          out_last_frame <= 1'b0;
        end
      end
    end
  end

endmodule
